// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler: ADC0808 multi-channel scan controller.
// Once per scan period, converts every channel enabled in a latched mask, in
// ascending order. Results go into an 8-entry result file that has per-channel
// unread ("fresh") flags.
module adc_scan_scheduler #(
  parameter int PULSE_CYCLES = 2,
  parameter int SCAN_PERIOD  = 1000,
  parameter int EOC_TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] ch_mask,
  input  logic       eoc,
  input  logic [7:0] adc_data,
  output logic [2:0] addr,
  output logic       ale,
  output logic       start,
  output logic       oe,
  output logic       sample_valid,
  output logic [2:0] sample_ch,
  output logic [7:0] sample_data,
  output logic       scan_done,
  output logic       timeout_err,
  input  logic [2:0] rd_ch,
  output logic [7:0] rd_data,
  output logic [7:0] rd_fresh,
  input  logic       rd_ack
);

  localparam int CNT_MAX = (PULSE_CYCLES > EOC_TIMEOUT) ? PULSE_CYCLES : EOC_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMR_W   = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(EOC_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SCAN_PERIOD - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SELECT, ST_START, ST_WAIT_LOW,
    ST_WAIT_HIGH, ST_READ1, ST_READ2, ST_NEXT
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       ch_q, ch_d;
  logic [7:0]       mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             eoc_meta_q, eoc_sync_q;
  logic [2:0]       addr_q, addr_d;
  logic             ale_q, ale_d;
  logic             start_q, start_d;
  logic             oe_q, oe_d;
  logic             sample_valid_q, sample_valid_d;
  logic [2:0]       sample_ch_q, sample_ch_d;
  logic [7:0]       sample_data_q, sample_data_d;
  logic             scan_done_q, scan_done_d;
  logic             timeout_err_q, timeout_err_d;
  logic [7:0]       result_q [8];
  logic [7:0]       result_d [8];
  logic [7:0]       fresh_q, fresh_d;
  logic             capture;
  logic [7:0]       upper_mask;

  // Index of the lowest set bit of a non-zero mask.
  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Mask bits strictly above the channel that was just converted.
  assign upper_mask = mask_q & (8'hFE << ch_q);

  // Next-state, scan sequencing, result-file and output-register logic.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d        = state_q;
    ch_d           = ch_q;
    mask_d         = mask_q;
    cnt_d          = cnt_q;
    timer_d        = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
    timeout_err_d  = timeout_err_q;
    sample_valid_d = 1'b0;
    sample_ch_d    = sample_ch_q;
    sample_data_d  = sample_data_q;
    scan_done_d    = 1'b0;
    result_d       = result_q;
    fresh_d        = fresh_q;
    capture        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!enable) timeout_err_d = 1'b0;
        if (enable && (ch_mask != 8'h00) && (timer_q == '0)) begin
          mask_d  = ch_mask;
          timer_d = TMR_RELOAD;
          ch_d    = lowest_bit(ch_mask);
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        cnt_d   = '0;
        state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT_LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOW, ST_WAIT_HIGH: begin
        // One budget spans both wait phases; a missed EOC pulse ends here.
        if (cnt_q >= WAIT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = ST_NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == ST_WAIT_LOW && !eoc_sync_q) state_d = ST_WAIT_HIGH;
          if (state_q == ST_WAIT_HIGH && eoc_sync_q) state_d = ST_READ1;
        end
      end
      ST_READ1: state_d = ST_READ2;
      ST_READ2: begin
        capture           = 1'b1;
        result_d[ch_q]    = adc_data;
        sample_valid_d    = 1'b1;
        sample_ch_d       = ch_q;
        sample_data_d     = adc_data;
        state_d           = ST_NEXT;
      end
      ST_NEXT: begin
        if (upper_mask != 8'h00) begin
          ch_d    = lowest_bit(upper_mask);
          state_d = ST_SELECT;
        end else begin
          scan_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Capture is applied after the ack so it wins on the same channel.
    if (rd_ack) fresh_d[rd_ch] = 1'b0;
    if (capture) fresh_d[ch_q] = 1'b1;

    // Pin outputs are decoded from the next state so they come straight off flops.
    addr_d  = (state_d == ST_SELECT) ? ch_d : addr_q;
    ale_d   = (state_d == ST_START);
    start_d = (state_d == ST_START);
    oe_d    = (state_d == ST_READ1) || (state_d == ST_READ2);
  end

  // State, EOC synchronizer and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      ch_q           <= '0;
      mask_q         <= '0;
      cnt_q          <= '0;
      timer_q        <= '0;
      eoc_meta_q     <= 1'b0;
      eoc_sync_q     <= 1'b0;
      addr_q         <= '0;
      ale_q          <= 1'b0;
      start_q        <= 1'b0;
      oe_q           <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      sample_data_q  <= '0;
      scan_done_q    <= 1'b0;
      timeout_err_q  <= 1'b0;
      // NOTE: the result file is reset because downstream readers may use rd_data before any scan.
      result_q       <= '{default: '0};
      fresh_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q        <= state_d;
      ch_q           <= ch_d;
      mask_q         <= mask_d;
      cnt_q          <= cnt_d;
      timer_q        <= timer_d;
      eoc_meta_q     <= eoc;
      eoc_sync_q     <= eoc_meta_q;
      addr_q         <= addr_d;
      ale_q          <= ale_d;
      start_q        <= start_d;
      oe_q           <= oe_d;
      sample_valid_q <= sample_valid_d;
      sample_ch_q    <= sample_ch_d;
      sample_data_q  <= sample_data_d;
      scan_done_q    <= scan_done_d;
      timeout_err_q  <= timeout_err_d;
      result_q       <= result_d;
      fresh_q        <= fresh_d;
    end
  end

  assign addr         = addr_q;
  assign ale          = ale_q;
  assign start        = start_q;
  assign oe           = oe_q;
  assign sample_valid = sample_valid_q;
  assign sample_ch    = sample_ch_q;
  assign sample_data  = sample_data_q;
  assign scan_done    = scan_done_q;
  assign timeout_err  = timeout_err_q;
  assign rd_data      = result_q[rd_ch];
  assign rd_fresh     = fresh_q;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed self-checking bench for adc_scan_scheduler, with a simple ADC0808 model.
module tb_adc_scan_scheduler;

  localparam int PULSE_CYCLES = 2;
  localparam int SCAN_PERIOD  = 100;
  localparam int EOC_TIMEOUT  = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] ch_mask = 8'h00;
  logic       eoc = 1'b1;
  logic [7:0] adc_data = 8'h00;
  logic [2:0] addr;
  logic       ale, start, oe;
  logic       sample_valid;
  logic [2:0] sample_ch;
  logic [7:0] sample_data;
  logic       scan_done, timeout_err;
  logic [2:0] rd_ch = 3'd0;
  logic [7:0] rd_data, rd_fresh;
  logic       rd_ack = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  adc_scan_scheduler #(
    .PULSE_CYCLES(PULSE_CYCLES),
    .SCAN_PERIOD (SCAN_PERIOD),
    .EOC_TIMEOUT (EOC_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask),
    .eoc(eoc), .adc_data(adc_data), .addr(addr), .ale(ale), .start(start),
    .oe(oe), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_data(sample_data), .scan_done(scan_done), .timeout_err(timeout_err),
    .rd_ch(rd_ch), .rd_data(rd_data), .rd_fresh(rd_fresh), .rd_ack(rd_ack)
  );

  always #5 clk = ~clk;

  // ADC model: EOC low for 10 cycles after START falls, then data = 8'h10 + channel.
  logic       use_fixed = 1'b1;
  logic [7:0] fixed_val = 8'hA5;
  logic       stuck_once = 1'b0;
  logic       start_prev = 1'b0;
  logic [2:0] latched_ch = 3'd0;
  int         low_cnt = 0;

  always @(negedge clk) begin
    if (start_prev && !start) begin
      latched_ch = addr;
      if (stuck_once) stuck_once = 1'b0;
      else begin
        eoc = 1'b0;
        low_cnt = 10;
      end
    end else if (low_cnt > 0) begin
      low_cnt--;
      if (low_cnt == 0) begin
        eoc = 1'b1;
        adc_data = use_fixed ? fixed_val : 8'h10 + {5'd0, latched_ch};
      end
    end
    start_prev = start;
  end

  // Cycle counter and output monitor.
  int          cyc = 0;
  int          ale_cycles = 0, start_cycles = 0, oe_cycles = 0, done_cnt = 0;
  logic        ale_prev = 1'b0;
  int          ale_rise[$];
  int          sv_cyc[$];
  logic [10:0] cap[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ale && !ale_prev) ale_rise.push_back(cyc);
    ale_prev = ale;
    if (ale) ale_cycles++;
    if (start) start_cycles++;
    if (oe) oe_cycles++;
    if (scan_done) done_cnt++;
    if (sample_valid) begin
      cap.push_back({sample_ch, sample_data});
      sv_cyc.push_back(cyc);
    end
  end

  task automatic clear_mon();
    ale_cycles = 0; start_cycles = 0; oe_cycles = 0; done_cnt = 0;
    ale_rise.delete(); sv_cyc.delete(); cap.delete();
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset values.
    repeat (3) step();
    check("rst_addr", addr, 0);
    check("rst_pins", {ale, start, oe}, 0);
    check("rst_sample", {sample_valid, sample_ch, sample_data}, 0);
    check("rst_done_err", {scan_done, timeout_err}, 0);
    check("rst_fresh", rd_fresh, 8'h00);
    check("rst_rd_data", rd_data, 8'h00);
    reset = 1'b0;
    repeat (3) step();

    // First-scan latency, single channel 0, fixed data A5.
    clear_mon();
    ch_mask = 8'h01;
    enable = 1'b1;
    for (int i = 0; i < 200 && done_cnt < 1; i++) step();
    enable = 1'b0;
    step();
    check("t1_done", done_cnt, 1);
    check("t1_ale_cycles", ale_cycles, 2);
    check("t1_start_cycles", start_cycles, 2);
    check("t1_oe_cycles", oe_cycles, 2);
    check("t1_nsamples", cap.size(), 1);
    check("t1_sample", (cap.size() > 0) ? cap[0] : 11'bx, {3'd0, 8'hA5});
    check("t1_fresh", rd_fresh, 8'h01);
    check("t1_addr", addr, 0);
    // SELECT(1)+START(2)+wait(13)+READ(2) = 18 cycles from SELECT entry; ALE rises one cycle after SELECT.
    check("t1_latency", (sv_cyc.size() > 0 && ale_rise.size() > 0) ? sv_cyc[0] - ale_rise[0] : -1, 17);

    // Ordered scan ch2, ch5, ch7 with model data 8'h10+ch.
    repeat (110) step();
    clear_mon();
    use_fixed = 1'b0;
    ch_mask = 8'b1010_0100;
    enable = 1'b1;
    for (int i = 0; i < 300 && done_cnt < 1; i++) step();
    step();
    check("t2_done", done_cnt, 1);
    check("t2_nsamples", cap.size(), 3);
    check("t2_cap0", (cap.size() > 0) ? cap[0] : 11'bx, {3'd2, 8'h12});
    check("t2_cap1", (cap.size() > 1) ? cap[1] : 11'bx, {3'd5, 8'h15});
    check("t2_cap2", (cap.size() > 2) ? cap[2] : 11'bx, {3'd7, 8'h17});
    check("t2_fresh", rd_fresh, 8'hA5);
    rd_ch = 3'd5;
    #1;
    check("t2_rd_data5", rd_data, 8'h15);
    for (int i = 0; i < 200 && ale_rise.size() < 4; i++) step();
    check("t2_period", (ale_rise.size() > 3) ? ale_rise[3] - ale_rise[0] : -1, SCAN_PERIOD);
    for (int i = 0; i < 200 && done_cnt < 2; i++) step();
    enable = 1'b0;
    check("t2_second_done", done_cnt, 2);

    // Timeout on ch0, ch1 still converts.
    repeat (110) step();
    clear_mon();
    stuck_once = 1'b1;
    ch_mask = 8'h03;
    enable = 1'b1;
    for (int i = 0; i < 300 && done_cnt < 1; i++) step();
    step();
    check("t3_done", done_cnt, 1);
    check("t3_timeout_err", timeout_err, 1);
    check("t3_nsamples", cap.size(), 1);
    check("t3_cap0", (cap.size() > 0) ? cap[0] : 11'bx, {3'd1, 8'h11});
    rd_ch = 3'd0;
    #1;
    check("t3_result0_kept", rd_data, 8'hA5);
    repeat (2) step();
    check("t3_err_sticky", timeout_err, 1);
    enable = 1'b0;
    repeat (2) step();
    check("t3_err_cleared", timeout_err, 0);

    // Mask change and disable mid-scan, plus read-port ack behaviour.
    repeat (110) step();
    clear_mon();
    rd_ch = 3'd2;
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    check("t4_ack_clear", rd_fresh, 8'hA3);
    ch_mask = 8'h0C;
    enable = 1'b1;
    for (int i = 0; i < 20 && ale !== 1'b1; i++) step();
    ch_mask = 8'h00;
    enable = 1'b0;
    check("t4_addr_ch2", addr, 2);
    for (int i = 0; i < 100 && oe !== 1'b1; i++) step();
    step();
    check("t4_oe_read2", oe, 1);
    rd_ch = 3'd2;
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    check("t4_capture_sv", {sample_valid, sample_ch, sample_data}, {1'b1, 3'd2, 8'h12});
    check("t4_capture_wins", rd_fresh[2], 1);
    for (int i = 0; i < 100 && done_cnt < 1; i++) step();
    step();
    check("t4_done", done_cnt, 1);
    check("t4_nsamples", cap.size(), 2);
    check("t4_cap1", (cap.size() > 1) ? cap[1] : 11'bx, {3'd3, 8'h13});
    repeat (150) step();
    check("t4_idle_ale", ale_cycles, 4);
    check("t4_idle_done", done_cnt, 1);
    rd_ch = 3'd3;
    #1;
    check("t4_rd_data3", rd_data, 8'h13);
    rd_ch = 3'd7;
    #1;
    check("t4_rd_data7", rd_data, 8'h17);
    rd_ch = 3'd2;
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    check("t4_late_ack", rd_fresh, 8'hAB);

    // Asynchronous reset while START is high.
    ch_mask = 8'h01;
    enable = 1'b1;
    for (int i = 0; i < 20 && start !== 1'b1; i++) step();
    check("t5_in_start", start, 1);
    reset = 1'b1;
    #1;
    check("t5_async_pins", {ale, start, oe}, 0);
    step();
    check("t5_rst_addr", addr, 0);
    check("t5_rst_sample", {sample_valid, sample_ch, sample_data}, 0);
    check("t5_rst_done_err", {scan_done, timeout_err}, 0);
    check("t5_rst_fresh", rd_fresh, 8'h00);
    for (int c = 0; c < 8; c++) begin
      rd_ch = 3'(c);
      #1;
      check($sformatf("t5_result%0d", c), rd_data, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_scan_scheduler.md
# adc_scan_scheduler

Multi-channel scan controller for the ADC0808. It drives the analog address, ALE, START and OE pins and captures conversion results, replacing the single-channel fixed-address sequencer. Each scan period it converts every channel enabled in a mask, in ascending order. Results go into an 8-entry result file with per-channel "fresh" flags, read by downstream logic (filters, UART reporting).

## Interface
Parameters:
- PULSE_CYCLES, 2: ALE/START high width in clk cycles (≥1).
- SCAN_PERIOD, 1000: clk cycles from one scan start to the next (≥1).
- EOC_TIMEOUT, 255: max clk cycles spent waiting for EOC per conversion (≥2).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high; clock clk
- enable  in  1  scanning allowed; sampled only in IDLE
- ch_mask  in  8  channel enable bits; latched at scan start
- eoc  in  1  ADC0808 end-of-conversion, synchronized to clk by a 2-flop synchronizer inside the block
- adc_data  in  8  ADC0808 D[7:0]
- addr  out  3  ADC0808 ADD C/B/A
- ale  out  1  address latch enable
- start  out  1  start conversion
- oe  out  1  output enable
- sample_valid  out  1  one-cycle pulse: new result captured
- sample_ch  out  3  channel of last capture
- sample_data  out  8  data of last capture
- scan_done  out  1  one-cycle pulse at end of scan
- timeout_err  out  1  sticky EOC timeout flag
- rd_ch  in  3  result-file read address
- rd_data  out  8  result[rd_ch], combinational
- rd_fresh  out  8  per-channel unread-result flags
- rd_ack  in  1  clears rd_fresh[rd_ch]

## Operation
- On reset, every output and register is cleared: addr=0, ale=start=oe=0, sample_*=0, scan_done=0, timeout_err=0, result file=0, rd_fresh=0, period timer=0, state=IDLE.
- Period timer:
  - Reloads SCAN_PERIOD-1 at each scan start.
  - Decrements to 0 and holds there.
  - Because it is 0 after reset, the first scan begins as soon as enable=1.
- The channel mask is latched at scan start. Changes to ch_mask during a scan have no effect until the next scan.
- States:
  - IDLE: if enable && ch_mask!=0 && timer==0, latch the mask, reload the timer, set ch = lowest set bit, go to SELECT. If ch_mask==0, stay in IDLE, with no scan_done.
  - SELECT: drive addr=ch for 1 cycle of address setup, then go to START.
  - START: ale=start=1 for PULSE_CYCLES cycles, then go to WAIT_LOW.
  - WAIT_LOW: wait for synchronized eoc==0, then go to WAIT_HIGH.
  - WAIT_HIGH: wait for eoc==1, then go to READ1.
  - READ1: oe=1.
  - READ2: oe=1. At the end of this cycle, capture adc_data into result[ch], set rd_fresh[ch], and load sample_ch and sample_data.
  - NEXT: pick the next set mask bit above ch and go to SELECT. If there is none, pulse scan_done and go to IDLE.
- Timeout:
  - One counter covers WAIT_LOW and WAIT_HIGH together, starting from 0 on entry to WAIT_LOW.
  - When it reaches EOC_TIMEOUT, set timeout_err and go to NEXT. result and rd_fresh are not updated and there is no sample_valid pulse.
  - timeout_err clears only on reset, or on an IDLE cycle with enable=0.
- enable=0 mid-scan: the current scan runs to completion.
- rd_ack clears rd_fresh[rd_ch]. If a capture and an ack hit the same channel in the same cycle, the capture wins and the flag stays 1.
- addr holds its last value outside SELECT..READ2. ale, start and oe are registered outputs, with no combinational glitches.

## Timing
- Per-channel latency, from SELECT entry to the sample_valid pulse: 1 + PULSE_CYCLES + (cycles in WAIT_LOW/WAIT_HIGH) + 2 cycles.
- sample_valid is high for exactly the one cycle after the READ2 capture edge. sample_ch and sample_data are valid in that cycle and hold until the next capture.
- NEXT takes 1 cycle. The next channel's SELECT therefore follows the sample_valid cycle.
- scan_done pulses in the cycle after the last channel's NEXT. A scan whose only channel timed out still pulses scan_done.
- eoc sees 2 cycles of synchronizer latency. An EOC low pulse shorter than 1 clk may be missed; the timeout covers that case.
- If the scan takes longer than SCAN_PERIOD, the next scan starts on the first IDLE cycle. Missed periods are not queued.
- Asynchronous reset mid-conversion drops ale, start and oe immediately.

## Test plan
- First-scan latency: reset, enable=1, ch_mask=8'h01, PULSE_CYCLES=2, ADC model holds EOC low 10 cycles and then drives 8'hA5.
  - addr=0, ale/start high 2 cycles, oe high 2 cycles.
  - sample_valid with ch 0 / 8'hA5, rd_fresh=8'h01, scan_done.
- Ordered scan: ch_mask=8'b1010_0100, model returns 8'h10+ch.
  - Captures in order ch2, ch5, ch7 with 8'h12, 8'h15, 8'h17.
  - Exactly 1 scan_done pulse.
  - Next scan starts exactly SCAN_PERIOD cycles after the first scan start.
- Timeout: model never drops EOC, EOC_TIMEOUT=20.
  - timeout_err=1, no sample_valid, result unchanged.
  - Next channel proceeds, scan_done still pulses.
  - timeout_err clears after enable=0 in IDLE.
- Mask change and disable mid-scan: change ch_mask to 8'h00 and drop enable during the ch2 conversion of 8'h0C.
  - ch3 is still converted, scan_done pulses, and the block then stays IDLE.
- Read port: ack ch2 in the same cycle that ch2 is captured, so rd_fresh[2] stays 1. A later ack clears it. rd_data=result[rd_ch] with 0 cycles of latency.
- Reset during START: ale, start and oe go 0 asynchronously. All outputs reach their reset values and the result file is 0.
